// File: rtl/toccata_pkg.sv
// Shared Toccata types and helpers: capture FSM states, frame sizing and
// the signed-to-offset-binary byte conversion used by the record path.
package toccata_pkg;

  typedef enum logic {CAP_IDLE, CAP_SEND} cap_state_t;

  // Number of bytes in one frame, minus one.
  function automatic logic [1:0] bytes_per_frame(input logic sm, input logic eight);
    if (eight) return sm ? 2'd1 : 2'd0;
    else       return sm ? 2'd3 : 2'd1;
  endfunction

  function automatic logic [7:0] to_u8(input logic signed [15:0] s);
    return {~s[15], s[14:8]};
  endfunction

endpackage

// File: rtl/toccata_byte_sel.sv
// Picks the frame byte at byte_idx from the latched sample registers,
// applying the 8-bit unsigned or 16-bit little-endian layout.
module toccata_byte_sel
  import toccata_pkg::*;
(
  input  logic [15:0] lat_l,
  input  logic [15:0] lat_m,
  input  logic [15:0] lat_r,
  input  logic        sm,
  input  logic        eight,
  input  logic [1:0]  byte_idx,
  output logic [7:0]  data
);

  always_comb begin
    data = 8'h00;
    if (eight) begin
      if (!sm)              data = to_u8(lat_m);
      else if (byte_idx[0]) data = to_u8(lat_r);
      else                  data = to_u8(lat_l);
    end else if (!sm) begin
      data = byte_idx[0] ? lat_m[15:8] : lat_m[7:0];
    end else begin
      case (byte_idx)
        2'd0:    data = lat_l[7:0];
        2'd1:    data = lat_l[15:8];
        2'd2:    data = lat_r[7:0];
        default: data = lat_r[15:8];
      endcase
    end
  end

endmodule

// File: rtl/toccata_capture.sv
// Record path: latches one ADC sample pair per strobe and streams the
// formatted frame bytes into the record FIFO, flagging dropped samples.
module toccata_capture
  import toccata_pkg::*;
#(
  parameter bit MONO_MIX = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        sm,
  input  logic        lc,
  input  logic        fmt,
  input  logic [15:0] adc_ldata,
  input  logic [15:0] adc_rdata,
  input  logic        adc_valid,
  output logic        rst_fifo,
  output logic        wr_en,
  output logic [7:0]  data_out,
  input  logic        fifo_full,
  output logic        busy,
  output logic        overrun,
  input  logic        ovr_clr
);

  cap_state_t  state, state_nxt;
  logic [1:0]  byte_idx;
  logic [15:0] lat_l, lat_r, lat_m, mono;
  logic [16:0] mix_sum;
  logic [7:0]  sel_byte;
  logic        sm_q, lc_q, fmt_q, eight_q;
  logic        mode_chg, strobe, accept, last_byte, overrun_q;

  assign mode_chg  = (sm != sm_q) || (lc != lc_q) || (fmt != fmt_q);
  assign eight_q   = !fmt_q || lc_q;
  assign strobe    = adc_valid && cen && !mode_chg;
  assign accept    = (state == CAP_IDLE) && strobe && !fifo_full;
  assign last_byte = (byte_idx == bytes_per_frame(sm_q, eight_q));

  // Sign-extended sum, then arithmetic halving; cannot overflow 16 bits.
  assign mix_sum = {adc_ldata[15], adc_ldata} + {adc_rdata[15], adc_rdata};
  assign mono    = MONO_MIX ? mix_sum[16:1] : adc_ldata;

  always_ff @(posedge clk) begin
    if (rst) state <= CAP_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CAP_IDLE: if (accept)               state_nxt = CAP_SEND;
      CAP_SEND: if (wr_en && last_byte)   state_nxt = CAP_IDLE;
      default:                            state_nxt = CAP_IDLE;
    endcase
    if (mode_chg) state_nxt = CAP_IDLE;
  end

  always_comb begin
    busy     = 1'b0;
    wr_en    = 1'b0;
    rst_fifo = rst || mode_chg;
    if (!rst && state == CAP_SEND) begin
      busy  = 1'b1;
      wr_en = !fifo_full && !mode_chg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sm_q      <= sm;
      lc_q      <= lc;
      fmt_q     <= fmt;
      lat_l     <= 16'h0000;
      lat_r     <= 16'h0000;
      lat_m     <= 16'h0000;
      byte_idx  <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      sm_q  <= sm;
      lc_q  <= lc;
      fmt_q <= fmt;
      if (accept) begin
        lat_l    <= adc_ldata;
        lat_r    <= adc_rdata;
        lat_m    <= mono;
        byte_idx <= 2'd0;
      end else if (wr_en) begin
        byte_idx <= byte_idx + 2'd1;
      end
      // A new drop outranks a clear in the same cycle.
      if (strobe && (state == CAP_SEND || fifo_full)) overrun_q <= 1'b1;
      else if (ovr_clr)                               overrun_q <= 1'b0;
    end
  end

  toccata_byte_sel u_byte_sel (
    .lat_l    (lat_l),
    .lat_m    (lat_m),
    .lat_r    (lat_r),
    .sm       (sm_q),
    .eight    (eight_q),
    .byte_idx (byte_idx),
    .data     (sel_byte)
  );

  assign data_out = busy ? sel_byte : 8'h00;
  assign overrun  = overrun_q && !rst;

endmodule

// File: doc/toccata_capture.md
Name: toccata_capture

Overview:
- Record-side counterpart of the Toccata playback path.
- Accepts one stereo 16-bit signed sample per strobe from the codec ADC side.
- Formats each sample per the Toccata mode bits (mono/stereo, 8-bit unsigned / 16-bit two's complement).
- Writes the resulting bytes one per cycle into the record FIFO that the Amiga bus side drains; flags overruns.

Parameters:
- MONO_MIX, 0: mono source select. 0 = left channel only; 1 = signed average of L and R.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cen  in  1  capture enable (0 = ignore ADC strobes)
- sm  in  1  0 mono, 1 stereo
- lc  in  1  1 companded (not supported; treated as 8-bit linear)
- fmt  in  1  0 8-bit unsigned, 1 16-bit two's complement
- adc_ldata  in  16  left ADC sample, signed
- adc_rdata  in  16  right ADC sample, signed
- adc_valid  in  1  one-cycle strobe, new sample pair valid
- rst_fifo  out  1  one-cycle FIFO reset request
- wr_en  out  1  FIFO write enable
- data_out  out  8  FIFO write data
- fifo_full  in  1  FIFO full, combinational from FIFO
- busy  out  1  frame in progress
- overrun  out  1  sticky: sample dropped
- ovr_clr  in  1  clear overrun

Behaviour:
- Clock and reset: clk; reset rst, synchronous, active-high.
- Reset outputs:
  - rst_fifo=1 for the reset cycles.
  - wr_en=0, busy=0, overrun=0, data_out=8'h00.
  - FSM to IDLE; latched sample registers cleared.
- Mode: eight = fmt==0 || lc==1.
- Bytes per frame: 8-bit mono 1; 8-bit stereo 2; 16-bit mono 2; 16-bit stereo 4.
- Byte order:
  - 8-bit mono: M.
  - 8-bit stereo: L, R.
  - 16-bit mono: M[7:0], M[15:8].
  - 16-bit stereo: L[7:0], L[15:8], R[7:0], R[15:8].
- 8-bit conversion: byte = {~s[15], s[14:8]} (signed MSB to unsigned; 0x0000 -> 0x80, 0x8000 -> 0x00, 0x7FFF -> 0xFF).
- Mono source M:
  - MONO_MIX=0: adc_ldata.
  - MONO_MIX=1: (sign-extended L + R) >>> 1, 17-bit intermediate, result truncated to 16 bits (no overflow possible).
- FSM states:
  - IDLE:
    - adc_valid && cen && !fifo_full: latch L, R/M, byte_idx=0, go SEND.
    - adc_valid && cen && fifo_full: drop the sample, set overrun, stay IDLE.
  - SEND:
    - busy=1; data_out = byte selected by byte_idx (combinational mux of latched regs).
    - wr_en = !fifo_full (combinational); never asserted while fifo_full=1.
    - On a cycle with wr_en=1: byte_idx++; after the last byte, return to IDLE.
    - On fifo_full=1: stall and hold byte_idx; frame byte order is never broken.
- Latency: adc_valid at cycle N gives first wr_en at N+1; byte k at N+1+k with no stalls; back in IDLE (busy=0) at N+1+bytes.
- adc_valid while in SEND: the sample is dropped and overrun set; the in-progress frame continues.
- cen deassert mid-frame: the current frame completes; later strobes are ignored. No overrun while cen=0.
- Mode change:
  - Any change of sm, lc, or fmt vs. previous-cycle registered copies: rst_fifo=1 for one cycle, FSM to IDLE, in-progress frame abandoned, wr_en=0 that cycle.
  - The strobe in the same cycle as a mode change is dropped without overrun.
- Overrun precedence: set and ovr_clr in the same cycle leaves overrun=1 (set wins).
- rst mid-frame: immediate return to the reset state; no partial bytes written afterward.

Decomposition:
- Extend toccata_pkg (shared with playback):
  - capture state enum {CAP_IDLE, CAP_SEND};
  - function bytes_per_frame(sm, eight) returning 2-bit count-1;
  - function to_u8(logic signed [15:0]).
- One combinational sub-module toccata_byte_sel: inputs latched L, M, R, sm, eight, byte_idx; output data byte. Keeps the format mux reusable and separately testable.
- FSM, counters, and overrun logic stay in toccata_capture.

Test Plan:
- 8-bit mono:
  - Stimulus: sm=0, fmt=0, cen=1, adc_valid with L=16'h1234, R=16'hFFFF.
  - Required: single wr_en at N+1, data_out=8'h92; busy low at N+2.
- 16-bit stereo:
  - Stimulus: L=16'hA55A, R=16'h0102.
  - Required: wr_en at N+1..N+4 with bytes 5A, A5, 02, 01.
- Backpressure:
  - Stimulus: 16-bit stereo, fifo_full=1 for 3 cycles after the 2nd byte.
  - Required: bytes 5A, A5 written, wr_en=0 for 3 cycles, then 02, 01; byte order intact; no overrun.
- Overrun:
  - Stimulus: adc_valid again while busy; separately adc_valid in IDLE with fifo_full=1.
  - Required: both samples dropped, overrun=1.
  - Then ovr_clr together with a new drop: overrun stays 1. ovr_clr alone: overrun=0.
- Mode change mid-frame:
  - Stimulus: toggle fmt during the 2nd byte of a stereo frame.
  - Required: rst_fifo one-cycle pulse, wr_en=0, busy=0 next cycle.
- MONO_MIX=1:
  - Stimulus: L=16'h7FFF, R=16'h7FFF, 16-bit mono.
  - Required: bytes FF, 7F.
  - Stimulus: L=16'h8000, R=16'h7FFF.
  - Required: bytes FF, FF (-1).
